sa_write_buffer: RTL

- Downstream consumer of the use-bit updater. Queues status-array (SA) write requests from two producers in a small FIFO and drives the single SA write port.
- Producer 1: use-bit updates from the hit path. Producer 2: fill writes from the miss/refill path.
- Coalesces same-index writes and provides a read bypass, so lookups see pending SA state before it is committed.

---
 rtl/sa_pkg.sv | 18 +
 rtl/sa_way_merge.sv | 26 ++
 rtl/sa_write_buffer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared constants and entry type for the status-array write path.
package sa_pkg;

  localparam int SA_WORD_WIDTH = 8;
  localparam int NUM_WAYS      = 4;
  localparam int INDEX_WIDTH   = 6;
  localparam int WAY_BITS      = SA_WORD_WIDTH / NUM_WAYS;
  localparam int USE_BIT_IDX   = 0;
  localparam int VALID_BIT_IDX = 1;

  // One pending SA write: target set, word, and per-way write enable.
  typedef struct packed {
    logic [INDEX_WIDTH-1:0]   index;
    logic [SA_WORD_WIDTH-1:0] data;
    logic [NUM_WAYS-1:0]      mask;
  } sa_entry_t;

endpackage

// File: rtl/sa_way_merge.sv
// Per-way merge of a newer masked SA word over an older one.
// Ways enabled in new_mask take new bits; other ways keep the old bits.
module sa_way_merge
  import sa_pkg::*;
(
  input  logic [SA_WORD_WIDTH-1:0] old_data,
  input  logic [NUM_WAYS-1:0]      old_mask,
  input  logic [SA_WORD_WIDTH-1:0] new_data,
  input  logic [NUM_WAYS-1:0]      new_mask,
  output logic [SA_WORD_WIDTH-1:0] merged_data,
  output logic [NUM_WAYS-1:0]      merged_mask
);

  // Overwrite each enabled way with the newer bits.
  always_comb begin
    merged_data = old_data;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (new_mask[w]) begin
        merged_data[w*WAY_BITS +: WAY_BITS] = new_data[w*WAY_BITS +: WAY_BITS];
      end
    end
  end

  assign merged_mask = old_mask | new_mask;

endmodule

// File: rtl/sa_write_buffer.sv
// Small coalescing write FIFO in front of the single SA write port.
// Fills are handled before use-bit updates; updates are dropped (and
// counted) when they can neither coalesce nor find space.
module sa_write_buffer
  import sa_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_upd_valid,
  input  logic [INDEX_WIDTH-1:0]   i_upd_index,
  input  logic [SA_WORD_WIDTH-1:0] i_upd_data,
  input  logic [NUM_WAYS-1:0]      i_upd_mask,
  input  logic                     i_fill_valid,
  input  logic [INDEX_WIDTH-1:0]   i_fill_index,
  input  logic [SA_WORD_WIDTH-1:0] i_fill_data,
  input  logic [NUM_WAYS-1:0]      i_fill_mask,
  output logic                     o_fill_ready,
  output logic                     o_sa_w_en,
  output logic [INDEX_WIDTH-1:0]   o_sa_w_addr,
  output logic [SA_WORD_WIDTH-1:0] o_sa_w_data,
  output logic [NUM_WAYS-1:0]      o_sa_w_mask,
  input  logic                     i_sa_w_ready,
  input  logic [INDEX_WIDTH-1:0]   i_rd_index,
  output logic                     o_byp_hit,
  output logic [SA_WORD_WIDTH-1:0] o_byp_data,
  output logic [NUM_WAYS-1:0]      o_byp_mask,
  output logic [7:0]               o_drop_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  sa_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, tail_ptr, next_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       drop_count;

  sa_entry_t head, tail, fill_e, upd_e, m1_e, base2_e, m2_e;
  logic [SA_WORD_WIDTH-1:0] m1_data, m2_data;
  logic [NUM_WAYS-1:0]      m1_mask, m2_mask;
  logic [INDEX_WIDTH-1:0]   upd_tail_index;

  logic not_empty, pop, tail_ok, fill_ready, fill_acc, fill_coal, fill_enq;
  logic upd_coal, upd_enq, drop;

  assign tail_ptr = wr_ptr - PTR_W'(1);
  assign next_ptr = wr_ptr + PTR_W'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];
  assign fill_e   = '{i_fill_index, i_fill_data, i_fill_mask};
  assign upd_e    = '{i_upd_index, i_upd_data, i_upd_mask};

  // Accept/coalesce/enqueue/drop decisions for this cycle. A popping
  // single entry is not a coalesce target. fill_ready only looks at the
  // tail when the buffer is full, where the tail is never the head, so it
  // stays independent of i_sa_w_ready.
  always_comb begin
    not_empty  = (count != '0);
    pop        = not_empty && i_sa_w_ready;
    tail_ok    = not_empty && !(pop && (count == CNT_W'(1)));
    fill_ready = (count < CNT_W'(DEPTH)) || (not_empty && (i_fill_index == tail.index));
    fill_acc   = i_fill_valid && fill_ready;
    fill_coal  = fill_acc && tail_ok && (i_fill_index == tail.index);
    fill_enq   = fill_acc && !fill_coal;
    upd_tail_index = fill_acc ? i_fill_index : tail.index;
    upd_coal   = i_upd_valid && (fill_acc || tail_ok) && (i_upd_index == upd_tail_index);
    upd_enq    = i_upd_valid && !upd_coal &&
                 ((count + CNT_W'(fill_enq)) < CNT_W'(DEPTH));
    drop       = i_upd_valid && !upd_coal && !upd_enq;
  end

  sa_way_merge u_fill_merge (
    .old_data    (tail.data),
    .old_mask    (tail.mask),
    .new_data    (i_fill_data),
    .new_mask    (i_fill_mask),
    .merged_data (m1_data),
    .merged_mask (m1_mask)
  );

  assign m1_e    = '{tail.index, m1_data, m1_mask};
  assign base2_e = fill_enq ? fill_e : (fill_coal ? m1_e : tail);

  sa_way_merge u_upd_merge (
    .old_data    (base2_e.data),
    .old_mask    (base2_e.mask),
    .new_data    (i_upd_data),
    .new_mask    (i_upd_mask),
    .merged_data (m2_data),
    .merged_mask (m2_mask)
  );

  assign m2_e = '{base2_e.index, m2_data, m2_mask};

  // Entry storage, pointers, occupancy and saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (fill_coal || (upd_coal && !fill_enq)) begin
        mem[tail_ptr] <= upd_coal ? m2_e : m1_e;
      end
      if (fill_enq) begin
        mem[wr_ptr] <= upd_coal ? m2_e : fill_e;
      end else if (upd_enq) begin
        mem[wr_ptr] <= upd_e;
      end
      if (fill_enq && upd_enq) begin
        mem[next_ptr] <= upd_e;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      wr_ptr <= wr_ptr + PTR_W'(fill_enq) + PTR_W'(upd_enq);
      count  <= count + CNT_W'(fill_enq) + CNT_W'(upd_enq) - CNT_W'(pop);
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign o_fill_ready = fill_ready;
  assign o_sa_w_en    = not_empty;
  assign o_sa_w_addr  = not_empty ? head.index : '0;
  assign o_sa_w_data  = not_empty ? head.data  : '0;
  assign o_sa_w_mask  = not_empty ? head.mask  : '0;
  assign o_drop_count = drop_count;

  sa_entry_t                age_e     [DEPTH];
  logic [DEPTH-1:0]         age_match;
  logic [SA_WORD_WIDTH-1:0] byp_d     [DEPTH+1];
  logic [NUM_WAYS-1:0]      byp_m     [DEPTH+1];

  // Present pending entries oldest first and flag those matching the lookup.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_e[k]     = mem[rd_ptr + PTR_W'(k)];
      age_match[k] = (CNT_W'(k) < count) && (age_e[k].index == i_rd_index);
    end
  end

  assign byp_d[0] = '0;
  assign byp_m[0] = '0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_byp
    sa_way_merge u_byp_merge (
      .old_data    (byp_d[k]),
      .old_mask    (byp_m[k]),
      .new_data    (age_e[k].data),
      .new_mask    (age_match[k] ? age_e[k].mask : '0),
      .merged_data (byp_d[k+1]),
      .merged_mask (byp_m[k+1])
    );
  end

  assign o_byp_hit  = |age_match;
  assign o_byp_data = byp_d[DEPTH];
  assign o_byp_mask = byp_m[DEPTH];

endmodule
